// File: rtl/dcp_pkt_switch.sv
// dcp_pkt_switch: SNUM-to-1 packet switch with round-robin or fixed-priority arbitration and a 2-entry output skid buffer; define DCP_SWITCH_STAT_EN to add per-channel packet counters on oPktCnt
module dcp_pkt_switch #(
    parameter int DW   = 8,
    parameter int SNUM = 4,
    parameter int MODE = 0
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [SNUM-1:0]           iInVld,
    input  logic [SNUM*DW-1:0]        iInData,
    input  logic [SNUM-1:0]           iInLast,
    output logic [SNUM-1:0]           oInRdy,
    output logic                      oOutVld,
    output logic [DW-1:0]             oOutData,
    output logic                      oOutLast,
    input  logic                      iOutRdy,
    output logic [$clog2(SNUM)-1:0]   oOutSel
`ifdef DCP_SWITCH_STAT_EN
    ,
    output logic [SNUM*16-1:0]        oPktCnt
`endif
);
    localparam int SW = $clog2(SNUM);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]      state, state_n;
    logic [SW-1:0]   ptr, ptr_n, gnt, gnt_n, gnt_inc, arb_idx;
    logic            arb_hit, acc, acc_last, pop;
    logic [1:0]      occ, occ_n;
    logic [SNUM-1:0] rdy_n;
    logic [DW-1:0]   buf_data [2];
    logic            buf_last [2];
    logic [SW-1:0]   buf_sel  [2];
    logic            wp, rp;

    function automatic logic [SW-1:0] wrap_idx(input int v);
        return SW'(v >= SNUM ? v - SNUM : v);
    endfunction

    // pick the requester closest above the search base: the pointer for round-robin, index 0 for fixed priority
    always_comb begin
        arb_hit = |iInVld;
        arb_idx = '0;
        for (int k = SNUM - 1; k >= 0; k--)
            if (iInVld[wrap_idx((MODE == 1 ? 0 : int'(ptr)) + k)])
                arb_idx = wrap_idx((MODE == 1 ? 0 : int'(ptr)) + k);
    end

    // handshakes, FSM transitions and the next registered ready, which looks at next-cycle occupancy
    always_comb begin
        acc      = state == LOCK && iInVld[gnt] && oInRdy[gnt];
        acc_last = acc && iInLast[gnt];
        pop      = oOutVld && iOutRdy;
        occ_n    = occ + {1'b0, acc} - {1'b0, pop};
        gnt_inc  = gnt == SW'(SNUM - 1) ? '0 : gnt + 1'b1;
        state_n  = state == IDLE ? (arb_hit ? LOCK : IDLE) : (acc_last ? IDLE : LOCK);
        gnt_n    = state == IDLE && arb_hit ? arb_idx : gnt;
        ptr_n    = acc_last ? gnt_inc : ptr;
        rdy_n    = state_n == LOCK && occ_n < 2'd2 ? SNUM'(1) << gnt_n : '0;
    end

    // control registers: FSM, grant, round-robin pointer, occupancy and input ready
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            occ    <= '0;
            oInRdy <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gnt    <= gnt_n;
            occ    <= occ_n;
            oInRdy <= rdy_n;
        end
    end

    // skid buffer storage: a push fills the write slot, a pop moves the read slot on
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wp       <= 1'b0;
            rp       <= 1'b0;
            buf_data <= '{'0, '0};
            buf_last <= '{1'b0, 1'b0};
            buf_sel  <= '{'0, '0};
        end else begin
            if (acc) begin
                buf_data[wp] <= iInData[int'(gnt)*DW +: DW];
                buf_last[wp] <= iInLast[gnt];
                buf_sel[wp]  <= gnt;
                wp           <= ~wp;
            end
            if (pop)
                rp <= ~rp;
        end
    end

    assign oOutVld  = occ != 2'd0;
    assign oOutData = buf_data[rp];
    assign oOutLast = buf_last[rp];
    assign oOutSel  = buf_sel[rp];

`ifdef DCP_SWITCH_STAT_EN
    // count a packet for its source when its last beat leaves the buffer
    always_ff @(posedge iClk) begin
        if (iRst)
            oPktCnt <= '0;
        else if (pop && oOutLast)
            oPktCnt[int'(oOutSel)*16 +: 16] <= oPktCnt[int'(oOutSel)*16 +: 16] + 16'd1;
    end
`endif
endmodule

// File: tb/tb_dcp_pkt_switch.sv
// tb_dcp_pkt_switch: scoreboard bench for dcp_pkt_switch (round-robin instance plus a fixed-priority instance); exercises oPktCnt when DCP_SWITCH_STAT_EN is defined
module tb_dcp_pkt_switch;
    localparam int DW = 8;
    localparam int SN = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic [SN-1:0] in_vld, in_last, in_rdy, gap;
    logic [SN*DW-1:0] in_data;
    logic out_vld, out_last, out_rdy;
    logic [DW-1:0] out_data;
    logic [1:0] out_sel;
    logic [SN-1:0] fp_vld, fp_rdy;
    logic fp_ovld, fp_olast;
    logic [DW-1:0] fp_odata;
    logic [1:0] fp_osel;
`ifdef DCP_SWITCH_STAT_EN
    logic [SN*16-1:0] pkt_cnt, fp_cnt;
`endif

    beat_t src_q[SN][$];
    beat_t exp_q[SN][$];
    int ord_q[$];
    int errors = 0, checks = 0, cyc = 0, pops = 0, first_pop = -1, last_pop = -1, fp_beats = 0;
    bit in_pkt = 0, hold = 0, gap_en = 0, rnd_rdy = 0, fp_run = 0;
    int cur_sel = 0;
    logic [DW-1:0] hd;
    logic hl;
    logic [1:0] hs;

    dcp_pkt_switch #(.DW(DW), .SNUM(SN), .MODE(0)) u_dut (
        .iClk(clk), .iRst(rst), .iInVld(in_vld), .iInData(in_data), .iInLast(in_last),
        .oInRdy(in_rdy), .oOutVld(out_vld), .oOutData(out_data), .oOutLast(out_last),
        .iOutRdy(out_rdy), .oOutSel(out_sel)
`ifdef DCP_SWITCH_STAT_EN
        , .oPktCnt(pkt_cnt)
`endif
    );

    dcp_pkt_switch #(.DW(DW), .SNUM(SN), .MODE(1)) u_fp (
        .iClk(clk), .iRst(rst), .iInVld(fp_vld), .iInData(32'h13121110), .iInLast(4'hF),
        .oInRdy(fp_rdy), .oOutVld(fp_ovld), .oOutData(fp_odata), .oOutLast(fp_olast),
        .iOutRdy(1'b1), .oOutSel(fp_osel)
`ifdef DCP_SWITCH_STAT_EN
        , .oPktCnt(fp_cnt)
`endif
    );

    always #5 clk = ~clk;

    // cycle stamp for throughput measurement
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void drive();
        for (int c = 0; c < SN; c++) begin
            in_vld[c]              = src_q[c].size() > 0 && !gap[c];
            in_data[c*DW +: DW]    = src_q[c].size() > 0 ? src_q[c][0].d : '0;
            in_last[c]             = src_q[c].size() > 0 && src_q[c][0].l;
        end
    endfunction

    function automatic int pending();
        int n = 0;
        for (int c = 0; c < SN; c++) n += src_q[c].size() + exp_q[c].size();
        return n;
    endfunction

    task automatic tick();
        logic [SN-1:0] acc;
        @(negedge clk);
        acc = in_vld & in_rdy;
        @(posedge clk);
        #1;
        for (int c = 0; c < SN; c++) if (acc[c]) void'(src_q[c].pop_front());
        for (int c = 0; c < SN; c++) gap[c] = gap_en && $urandom_range(0, 3) == 0;
        if (rnd_rdy) out_rdy = $urandom_range(0, 3) != 0;
        drive();
    endtask

    task automatic load(input int c, input logic [DW-1:0] d0, input int len, input bit rnd);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.d = rnd ? DW'($urandom) : d0 + DW'(i);
            b.l = i == len - 1;
            src_q[c].push_back(b);
            exp_q[c].push_back(b);
        end
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (pending() > 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (2) tick();
        chk("drain pending", pending(), 0);
        chk("drain idle vld", out_vld, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        for (int c = 0; c < SN; c++) begin
            src_q[c].delete();
            exp_q[c].delete();
        end
        ord_q.delete();
        in_pkt = 0;
        drive();
        tick();
        rst = 1'b0;
    endtask

    // scoreboard monitor: per-channel expected beats, packet contiguity, arbitration order and hold stability
    always @(negedge clk) begin
        beat_t b;
        int s;
        if (rst) hold = 0;
        else begin
            if (hold) begin
                chk("hold vld", out_vld, 1);
                chk("hold data", out_data, hd);
                chk("hold last", out_last, hl);
                chk("hold sel", out_sel, hs);
            end
            chk("rdy onehot0", $countones(in_rdy) <= 1, 1);
            if (out_vld && out_rdy) begin
                s = int'(out_sel);
                if (in_pkt) chk("interleave sel", out_sel, cur_sel);
                else if (ord_q.size() > 0) chk("arb order sel", out_sel, ord_q.pop_front());
                chk("beat expected on ch", exp_q[s].size() > 0, 1);
                if (exp_q[s].size() > 0) begin
                    b = exp_q[s].pop_front();
                    chk("out data", out_data, b.d);
                    chk("out last", out_last, b.l);
                end
                in_pkt  = !out_last;
                cur_sel = s;
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            hold = out_vld && !out_rdy;
            hd = out_data;
            hl = out_last;
            hs = out_sel;
        end
    end

    // fixed-priority instance: channel 0 must win every arbitration
    always @(negedge clk) begin
        if (fp_run && !rst) begin
            chk("fp starved rdy", fp_rdy[3:1], 0);
            if (fp_ovld) begin
                chk("fp sel", fp_osel, 0);
                chk("fp data", fp_odata, 8'h10);
                chk("fp last", fp_olast, 1);
                fp_beats++;
            end
        end
    end

    // directed scenarios followed by a randomized soak
    initial begin
        int p0;
        rst = 1'b1;
        out_rdy = 1'b1;
        gap = '0;
        fp_vld = '0;
        drive();
        repeat (3) tick();
        chk("reset vld", out_vld, 0);
        chk("reset rdy", in_rdy, 0);
        chk("reset data", out_data, 0);
        chk("reset last", out_last, 0);
        chk("reset sel", out_sel, 0);

        rst = 1'b0;
        for (int c = 0; c < SN; c++) begin
            load(c, 8'h10 + DW'(c), 1, 0);
            ord_q.push_back(c);
        end
        tick();
        chk("first arb rdy", in_rdy, 4'b0001);
        drain(100);

        fp_vld = 4'hF;
        fp_run = 1;
        repeat (40) tick();
        fp_run = 0;
        fp_vld = '0;
        chk("fp ch0 beats>=15", fp_beats >= 15, 1);

        load(2, 8'hA0, 4, 0);
        ord_q.push_back(2);
        repeat (2) tick();
        load(1, 8'h55, 1, 0);
        ord_q.push_back(1);
        drain(100);

        for (int c = 0; c < SN; c++) load(c, 8'h20 + DW'(c), 1, 0);
        ord_q.push_back(2);
        ord_q.push_back(3);
        ord_q.push_back(0);
        ord_q.push_back(1);
        drain(100);

        first_pop = -1;
        for (int p = 0; p < 4; p++) load(0, 8'h30 + DW'(p * 4), 3, 0);
        drain(100);
        chk("throughput span", last_pop - first_pop, 14);

        load(0, 8'hC0, 8, 0);
        p0 = pops;
        for (int n = 0; n < 50 && pops < p0 + 2; n++) tick();
        chk("stall start", pops >= p0 + 2, 1);
        out_rdy = 1'b0;
        repeat (5) tick();
        chk("stall rdy", in_rdy, 0);
        chk("stall vld", out_vld, 1);
        out_rdy = 1'b1;
        drain(100);

        load(1, 8'h60, 6, 0);
        repeat (3) tick();
        pulse_reset();
        chk("mid rst vld", out_vld, 0);
        chk("mid rst rdy", in_rdy, 0);
        for (int c = 0; c < SN; c++) begin
            load(c, 8'h70 + DW'(c), 1, 0);
            ord_q.push_back(c);
        end
        drain(100);

        pulse_reset();
        load(1, 8'h80, 2, 0);
        load(1, 8'h88, 1, 0);
        load(1, 8'h90, 3, 0);
        load(3, 8'hB0, 2, 0);
        drain(100);
`ifdef DCP_SWITCH_STAT_EN
        for (int c = 0; c < SN; c++)
            chk($sformatf("pkt cnt ch%0d", c), pkt_cnt[c*16 +: 16], c == 1 ? 3 : c == 3 ? 1 : 0);
        chk("fp cnt ch1", fp_cnt[31:16], 0);
`endif

        gap_en = 1;
        rnd_rdy = 1;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < SN; c++)
                if (src_q[c].size() == 0 && $urandom_range(0, 3) == 0)
                    load(c, 8'h00, $urandom_range(1, 5), 1);
            tick();
        end
        gap_en = 0;
        rnd_rdy = 0;
        gap = '0;
        out_rdy = 1'b1;
        drive();
        drain(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcp_pkt_switch.md
DCP_PKT_SWITCH -- requirements
Module: dcp_pkt_switch

Interface
- REQ-001 SHALL have parameter DW, default 8: data width in bits, range 1..512.
- REQ-002 SHALL have parameter SNUM, default 4: number of input channels, range 2..16.
- REQ-003 SHALL have parameter MODE, default 0: 0 selects round-robin arbitration, 1 selects fixed priority with the lowest index winning.
- REQ-004 SHALL have port `iClk`, input, 1 bit: the single clock; all logic is rising-edge.
- REQ-005 SHALL have port `iRst`, input, 1 bit: reset, synchronous and active-high.
- REQ-006 SHALL have port `iInVld`, input, SNUM bits: per-channel valid.
- REQ-007 SHALL have port `iInData`, input, SNUM*DW bits: channel i occupies bits [i*DW +: DW].
- REQ-008 SHALL have port `iInLast`, input, SNUM bits: per-channel last-beat-of-packet flag.
- REQ-009 SHALL have port `oInRdy`, output, SNUM bits: per-channel ready, driven from registers only.
- REQ-010 SHALL have ports `oOutVld` (1 bit), `oOutData` (DW bits) and `oOutLast` (1 bit), all outputs: the switched stream.
- REQ-011 SHALL have port `iOutRdy`, input, 1 bit: downstream ready.
- REQ-012 SHALL have port `oOutSel`, output, $clog2(SNUM) bits: the source index of the current `oOutData` beat.

Function
- REQ-013 SHALL transfer a beat on any port only in a cycle where Vld and Rdy are both 1 at the rising edge.
- REQ-014 SHALL implement a two-state FSM with states IDLE and LOCK.
- REQ-015 In IDLE, when any `iInVld` bit is 1, SHALL register a grant per MODE and move to LOCK at the next edge; `oInRdy` SHALL stay all-zero while in IDLE.
- REQ-016 Round-robin (MODE=0) SHALL search from the pointer upward, wrapping from index SNUM-1 to 0.
- REQ-017 After the last beat of a packet is accepted, the pointer SHALL become (granted+1) mod SNUM.
- REQ-018 In LOCK, only `oInRdy[grant]` SHALL ever be 1, and it SHALL be 1 when the skid buffer holds fewer than 2 entries.
- REQ-019 When a beat with `iInLast`=1 is accepted in LOCK, the FSM SHALL return to IDLE at that edge.
- REQ-020 Packets SHALL never interleave on the output; a single-beat packet is legal.
- REQ-021 The output stage SHALL be a 2-entry FIFO skid buffer holding data, last and source index.
- REQ-022 A beat accepted at edge N SHALL be visible on the output from edge N onwards (1-cycle latency), provided the buffer was empty.
- REQ-023 The buffer SHALL sustain one beat per cycle during LOCK; each packet SHALL add exactly one arbitration cycle, giving a steady-state throughput of L/(L+1) for packets of L beats.
- REQ-024 A simultaneous push and pop on the buffer SHALL leave the occupancy unchanged.
- REQ-025 When the buffer is full, `oInRdy` SHALL be 0 and no data SHALL be lost or duplicated.
- REQ-026 `oOutData`, `oOutLast` and `oOutSel` SHALL hold stable while `oOutVld`=1 and `iOutRdy`=0.
- REQ-027 An input that drops `iInVld` mid-packet SHALL keep the grant; the FSM waits in LOCK.

Reset
- REQ-028 While `iRst`=1, SHALL force: FSM to IDLE, pointer to 0, buffer empty, `oOutVld`=0, `oInRdy`=0, `oOutData`=0, `oOutLast`=0, `oOutSel`=0.
- REQ-029 A reset asserted mid-packet SHALL discard all buffered beats; no partial packet is emitted after reset.
- REQ-030 The first arbitration SHALL be possible in the cycle after `iRst` deasserts.

Configuration
- REQ-031 SHALL support the macro DCP_SWITCH_STAT_EN.
- REQ-032 With DCP_SWITCH_STAT_EN defined, SHALL add output `oPktCnt`, SNUM*16 bits, holding per-channel counts of completed output packets.
- REQ-033 Each `oPktCnt` count SHALL increment when a beat with `oOutLast`=1 is popped for that channel, SHALL wrap modulo 2^16, and SHALL reset to 0.
- REQ-034 Without DCP_SWITCH_STAT_EN, SHALL have no `oPktCnt` port and no counter logic, with all other behaviour identical.

Verification
- REQ-035 SHALL cover: channels 0-3 each send a 1-beat packet (data 0x10+i) simultaneously, `iOutRdy`=1, MODE=0 -> output order 0x10,0x11,0x12,0x13 with `oOutSel` 0,1,2,3.
- REQ-036 SHALL cover: the same stimulus with MODE=1 and channel 0 continuously re-requesting -> channel 0 wins every arbitration and channels 1-3 are starved.
- REQ-037 SHALL cover: a 4-beat packet on channel 2 (0xA0..0xA3) against a 1-beat packet on channel 1 arriving at beat 2 -> 0xA0..0xA3 emitted contiguously before channel 1.
- REQ-038 SHALL cover: `iOutRdy`=0 for 5 cycles during a packet -> `oInRdy` drops after 2 beats are buffered, output held stable, no loss after `iOutRdy` returns.
- REQ-039 SHALL cover: `iRst` pulsed for 1 cycle mid-packet -> next cycle `oOutVld`=0 and `oInRdy`=0, pointer 0, clean packets afterwards.
- REQ-040 SHALL cover: with DCP_SWITCH_STAT_EN, 3 packets from channel 1 and 1 from channel 3 -> `oPktCnt`[1]=3, `oPktCnt`[3]=1, all others 0.
